// File: rtl/ifu_pkg.sv
// ifu_pkg: opcodes, state encoding and reset PC shared by the fetch unit and control unit
package ifu_pkg;
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] FUNCT_JR = 6'h08;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;
endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction memory req/ack fetch channel
interface ifu_if;
  logic req;
  logic [31:0] addr;
  logic ack;
  logic [31:0] rdata;
  modport master(output req, addr, input ack, rdata);
  modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/ifu_npc.sv
// ifu_npc: combinational next-PC selector (jr > jump > taken branch > sequential)
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic [25:0] i_instr_idx,
  input  logic [31:0] i_rs_data,
  input  logic        i_jr_sel,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic        i_zero,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  assign w_br_tgt = i_pc_plus4 + {{14{i_instr_idx[15]}}, i_instr_idx[15:0], 2'b00};
  assign w_j_tgt = {i_pc_plus4[31:28], i_instr_idx, 2'b00};
  assign o_next_pc = i_jr_sel ? i_rs_data : i_jump ? w_j_tgt : (i_branch & i_zero) ? w_br_tgt : i_pc_plus4;
  assign o_misalign = i_jr_sel & (|i_rs_data[1:0]);
endmodule

// File: rtl/ifu.sv
// ifu: owns the PC, fetches over req/ack and gates control with protect outside EXEC
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
  input  logic        clk,
  input  logic        reset,
  ifu_if.master       imem,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic        o_protect,
  input  logic        i_branch,
  input  logic        i_jump,
  input  logic        i_zero,
  input  logic        i_jr_sel,
  input  logic [31:0] i_rs_data,
  input  logic        i_stall,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_fault
);
  state_t r_state, w_next;
  logic [31:0] r_pc, r_instr, w_next_pc;
  logic r_fault, w_misalign, w_retire;
  ifu_npc u_npc (
    .i_pc_plus4(o_pc_plus4),
    .i_instr_idx(r_instr[25:0]),
    .i_rs_data(i_rs_data),
    .i_jr_sel(i_jr_sel),
    .i_jump(i_jump),
    .i_branch(i_branch),
    .i_zero(i_zero),
    .o_next_pc(w_next_pc),
    .o_misalign(w_misalign)
  );
  assign w_retire = (r_state == EXEC) & ~i_stall;
  always_comb begin
    w_next = r_state;
    case (r_state)
      BOOT:  w_next = FETCH;
      FETCH: w_next = imem.ack ? EXEC : FETCH;
      EXEC:  w_next = i_stall ? EXEC : w_misalign ? HALT : FETCH;
      default: w_next = HALT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc <= PC_RESET;
      r_instr <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem.ack) r_instr <= imem.rdata;
      if (w_retire && w_misalign) r_fault <= 1'b1;
      if (w_retire && !w_misalign) r_pc <= w_next_pc;
    end
  end
  assign imem.req = r_state == FETCH;
  assign imem.addr = r_pc;
  assign o_protect = r_state != EXEC;
  assign o_instr = r_instr;
  assign o_opcode = r_instr[31:26];
  assign o_pc = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;
  assign o_fault = r_fault;
endmodule

// File: tb/tb_ifu.sv
// tb_ifu: vector table, hand sequences and randomized run against a next-PC reference model
module tb_ifu;
  import ifu_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic br, jmp, zr, jr, stall;
  logic [31:0] rs;
  logic [31:0] o_instr, o_pc, o_pc_plus4;
  logic [5:0] o_opcode;
  logic o_protect, o_fault;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ifu_if imem();
  ifu dut (
    .clk(clk), .reset(reset), .imem(imem),
    .o_instr(o_instr), .o_opcode(o_opcode), .o_protect(o_protect),
    .i_branch(br), .i_jump(jmp), .i_zero(zr), .i_jr_sel(jr), .i_rs_data(rs),
    .i_stall(stall), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_fault(o_fault)
  );
  typedef struct {
    logic [31:0] pc, word;
    logic b, j, z, r;
    logic [31:0] rsv, nxt;
    logic flt;
  } vec_t;
  vec_t tv[11];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    br = 0; jmp = 0; zr = 0; jr = 0; rs = 0; stall = 0;
    imem.ack = 0; imem.rdata = 0;
  endtask
  task automatic do_reset();
    clr();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask
  task automatic fetch(input logic [31:0] word, input int lat, output logic [31:0] addr);
    int n = 0;
    while (!imem.req && n < 20) begin
      step();
      n++;
    end
    chk("fetch_req", imem.req, 1);
    addr = imem.addr;
    repeat (lat) begin
      imem.ack = 0;
      step();
      chk("slow_addr_stable", imem.addr, addr);
      chk("slow_protect", o_protect, 1);
    end
    imem.ack = 1;
    imem.rdata = word;
    step();
    imem.ack = 0;
    chk("exec_protect", o_protect, 0);
    chk("instr_latched", o_instr, word);
  endtask
  task automatic exec(input logic b, j, z, r, input logic [31:0] rsv, input int nstall, input bit noise);
    logic [31:0] pc0, i0;
    pc0 = o_pc;
    i0 = o_instr;
    br = b; jmp = j; zr = z; jr = r; rs = rsv;
    stall = 1;
    repeat (nstall) begin
      if (noise) begin imem.ack = 1; imem.rdata = $urandom; end
      step();
      chk("stall_protect", o_protect, 0);
      chk("stall_pc", o_pc, pc0);
      chk("stall_instr", o_instr, i0);
      chk("stall_fault", o_fault, 0);
    end
    stall = 0;
    if (noise) begin imem.ack = 1; imem.rdata = $urandom; end
    step();
    clr();
  endtask
  function automatic logic [31:0] model_npc(input logic [31:0] pc, w, input logic b, j, z, r, input logic [31:0] rsv);
    int off;
    off = int'($signed(w[15:0]));
    if (r) return rsv;
    if (j) return ((pc + 4) & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    if (b && z) return pc + 4 + 32'(off * 4);
    return pc + 4;
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [31:0] a, w, rsv, tmp;
    logic b, j, z, r;
    tv[0]  = '{32'h3010, {OP_BEQ, 10'h0, 16'hFFFF}, 1, 0, 1, 0, 0, 32'h3010, 0};
    tv[1]  = '{32'h3010, {OP_BEQ, 10'h0, 16'hFFFF}, 1, 0, 0, 0, 0, 32'h3014, 0};
    tv[2]  = '{32'h3000, {OP_JAL, 26'h0000C10}, 0, 1, 0, 0, 0, 32'h3040, 0};
    tv[3]  = '{32'h3000, {OP_R_TYPE, 20'h0, FUNCT_JR}, 0, 0, 0, 1, 32'h3020, 32'h3020, 0};
    tv[4]  = '{32'h3000, {OP_R_TYPE, 20'h0, FUNCT_JR}, 0, 0, 0, 1, 32'h3022, 0, 1};
    tv[5]  = '{32'hFFFF_FFFC, {OP_ORI, 26'h1}, 0, 0, 0, 0, 0, 32'h0, 0};
    tv[6]  = '{32'h3000, {OP_BEQ, 10'h0, 16'h0004}, 1, 0, 1, 0, 0, 32'h3014, 0};
    tv[7]  = '{32'h3000, {OP_BEQ, 10'h0, 16'h0004}, 0, 0, 1, 0, 0, 32'h3004, 0};
    tv[8]  = '{32'h0, {OP_BEQ, 10'h0, 16'hFFFE}, 1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0};
    tv[9]  = '{32'hF000_0000, {OP_J, 26'h3}, 0, 1, 0, 0, 0, 32'hF000_000C, 0};
    tv[10] = '{32'h3000, {OP_J, 26'h100}, 1, 1, 1, 1, 32'h5000, 32'h5000, 0};
    clr();
    reset = 1;
    step();
    chk("rst_req", imem.req, 0);
    chk("rst_protect", o_protect, 1);
    chk("rst_pc", o_pc, 32'h3000);
    chk("rst_instr", o_instr, 0);
    chk("rst_fault", o_fault, 0);
    reset = 0;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("seq_protect", o_protect, ((k % 2) == 0) ? 1 : 0);
      if (k % 2 == 0) begin
        chk("seq_req", imem.req, 1);
        chk("seq_addr", imem.addr, 32'h3000 + 32'(4 * (k / 2)));
        imem.ack = 1;
        imem.rdata = {OP_ORI, 26'(k)};
      end
      step();
      imem.ack = 0;
    end
    for (int c = 0; c < 4; c++) begin
      chk("slow_req", imem.req, 1);
      chk("slow_addr", imem.addr, 32'h300C);
      chk("slow_prot", o_protect, 1);
      imem.ack = (c == 3);
      step();
    end
    imem.ack = 0;
    chk("slow_exec", o_protect, 0);
    step();
    chk("slow_one_exec", o_protect, 1);
    chk("slow_next_addr", imem.addr, 32'h3010);
    fetch({OP_R_TYPE, 20'h0, FUNCT_JR}, 0, a);
    jr = 1; rs = 32'h3022; stall = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("stall_jr_protect", o_protect, 0);
      chk("stall_jr_fault", o_fault, 0);
      chk("stall_jr_pc", o_pc, 32'h3010);
    end
    stall = 0; rs = 32'h3024;
    step();
    clr();
    chk("stall_release_protect", o_protect, 1);
    chk("stall_release_fault", o_fault, 0);
    chk("stall_release_addr", imem.addr, 32'h3024);
    imem.ack = 1;
    imem.rdata = 32'hDEAD_BEEF;
    reset = 1;
    #1;
    chk("midrst_req", imem.req, 0);
    chk("midrst_pc", o_pc, 32'h3000);
    chk("midrst_protect", o_protect, 1);
    step();
    reset = 0;
    step();
    imem.ack = 0;
    chk("midrst_instr", o_instr, 0);
    chk("midrst_req_after", imem.req, 1);
    chk("midrst_addr", imem.addr, 32'h3000);
    for (int i = 0; i < 11; i++) begin
      do_reset();
      fetch(32'h0, 0, a);
      chk("vec_boot_addr", a, 32'h3000);
      exec(0, 0, 0, 1, tv[i].pc, 0, 0);
      fetch(tv[i].word, 0, a);
      chk("vec_addr", a, tv[i].pc);
      chk("vec_pc_plus4", o_pc_plus4, tv[i].pc + 4);
      chk("vec_opcode", o_opcode, tv[i].word[31:26]);
      exec(tv[i].b, tv[i].j, tv[i].z, tv[i].r, tv[i].rsv, 0, 0);
      if (tv[i].flt) begin
        for (int c = 0; c < 3; c++) begin
          imem.ack = 1;
          chk("halt_fault", o_fault, 1);
          chk("halt_req", imem.req, 0);
          chk("halt_protect", o_protect, 1);
          chk("halt_pc", o_pc, tv[i].pc);
          step();
        end
        imem.ack = 0;
      end else begin
        fetch(32'h0, 0, a);
        chk("vec_next", a, tv[i].nxt);
        chk("vec_no_fault", o_fault, 0);
      end
    end
    do_reset();
    a = 32'h3000;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] mpc;
      mpc = (n == 0) ? 32'h3000 : a;
      br = 1'($urandom); jmp = 1'($urandom); zr = 1'($urandom); jr = 1'($urandom); rs = $urandom;
      w = $urandom;
      fetch(w, $urandom_range(0, 3), tmp);
      chk("rnd_addr", tmp, mpc);
      chk("rnd_pc", o_pc, mpc);
      chk("rnd_pc_plus4", o_pc_plus4, mpc + 4);
      r = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 3) == 0);
      z = 1'($urandom);
      tmp = $urandom;
      rsv = ($urandom_range(0, 4) == 0) ? tmp : (tmp & 32'hFFFF_FFFC);
      exec(b, j, z, r, rsv, $urandom_range(0, 2), 1'($urandom));
      if (r && rsv[1:0] != 2'b00) begin
        chk("rnd_halt_fault", o_fault, 1);
        chk("rnd_halt_req", imem.req, 0);
        chk("rnd_halt_protect", o_protect, 1);
        do_reset();
        chk("rnd_reset_fault", o_fault, 0);
        a = 32'h3000;
      end else begin
        a = model_npc(mpc, w, b, j, z, r, rsv);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-cycle MIPS core, sitting on the producer side of the main control unit. It owns the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents the opcode to the control unit. It drives `protect` so that control outputs are zeroed whenever no valid instruction is executing. It consumes the resulting `Branch`/`Jump` decisions to compute the next PC.

## Interface
- `PC_RESET`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req`  out  1  fetch request; held until `imem_ack`.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered current instruction.
- `opcode`  out  6  `instr[31:26]`, to control unit `instr`.
- `protect`  out  1  1 = suppress all control outputs (bubble).
- `Branch`, `Jump`  in  1 each  from control unit.
- `zero`  in  1  ALU zero flag.
- `jr_sel`  in  1  jump-register select (R-type funct 001000).
- `rs_data`  in  32  register rs value for jr.
- `stall`  in  1  hold the current instruction in EXEC (data memory busy).
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc`+4, used as the jal link value.
- `fault`  out  1  sticky misaligned-jr flag.

## Operation
- States: BOOT, FETCH, EXEC, HALT.
- On `reset`:
  - state=BOOT, `pc`=PC_RESET, `instr`=0, `fault`=0.
  - Outputs: `protect`=1, `imem_req`=0.
- BOOT: next cycle goes to FETCH unconditionally.
- FETCH:
  - `imem_req`=1, `protect`=1.
  - On `imem_ack`, `instr`<=`imem_rdata` and the next state is EXEC.
  - Without `imem_ack`, the state stays FETCH with `imem_addr` stable.
- EXEC:
  - `protect`=0 and `imem_req`=0.
  - If `stall`=1: hold state, `pc` and `instr`.
  - Otherwise: `pc`<=next_pc and the next state is FETCH.
  - Exception: if `jr_sel`=1 and `rs_data[1:0]`≠0, set `fault`<=1, leave `pc` unchanged, and go to HALT.
- HALT: `protect`=1, `imem_req`=0. Only `reset` exits this state.
- next_pc, highest priority first:
  1. `jr_sel`: `rs_data`.
  2. `Jump`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  3. `Branch`&`zero`: `pc_plus4` + {sign-extended `instr[15:0]`, 2'b00}.
  4. Otherwise: `pc_plus4`.
- All PC arithmetic is 32-bit modulo 2^32. Wrap past 32'hFFFF_FFFC to 0 is legal and raises no fault.
- `Branch` with `zero`=0 selects `pc_plus4`.
- `Branch`/`Jump`/`jr_sel` are sampled only in EXEC; they are ignored in every other state.
- `imem_ack` outside FETCH is ignored.

## Timing
- Minimum 2 cycles per instruction: a 1-cycle FETCH (ack in the same cycle as req) followed by a 1-cycle EXEC.
- Each memory wait cycle adds 1 cycle; each `stall` cycle adds 1 cycle.
- `protect` is registered-state decoded (state≠EXEC). It falls on the first EXEC cycle and rises on the cycle after EXEC completes.
- The `instr`/`opcode` update is visible in the same cycle `protect` falls.
- The `pc` update is visible on the first FETCH cycle after EXEC.
- Reset mid-FETCH:
  - `imem_req` drops asynchronously.
  - Any ack arriving during reset or BOOT is ignored.
  - The first post-reset request goes to PC_RESET.
- `stall` together with `jr_sel` misaligned: `stall` wins. `fault` is evaluated only on the non-stalled EXEC cycle.

## Structure
- Shared package:
  - opcode constants (R_TYPE, BEQ, ORI, LW, SW, JAL, J, shared with the control unit definitions),
  - the JR funct code,
  - the 2-bit state encoding (BOOT=0, FETCH=1, EXEC=2, HALT=3),
  - the PC_RESET default.
- Sub-module `npc`: purely combinational next-PC selector. Inputs `pc_plus4`, `instr[25:0]`, `rs_data`, `jr_sel`, `Jump`, `Branch`, `zero`; outputs `next_pc` and `misalign`.
- The top level holds the FSM, the `pc`/`instr`/`fault` registers and the handshake.

## Test plan
- Sequential fetch:
  - Stimulus: reset release, ack latency 0, three non-branch instructions.
  - Response: `imem_addr` = 0x3000, 0x3004, 0x3008. `protect` pattern 1,0,1,0,1,0 from the first FETCH.
- Slow memory:
  - Stimulus: ack after 3 cycles.
  - Response: `imem_req` high for 4 cycles with `imem_addr` stable; `protect`=1 throughout; exactly one EXEC follows.
- beq at 0x3010, imm=0xFFFF (−1):
  - With `Branch`=1, `zero`=1: next fetch at 0x3010.
  - With `zero`=0: next fetch at 0x3014.
- jal at 0x3000, `instr[25:0]`=0x0000C10: next fetch at 0x0000_3040; `pc_plus4`=0x3004 during EXEC.
- jr:
  - `rs_data`=0x3022 with `jr_sel`=1: `fault`=1, HALT, `protect` stays 1, no further `imem_req`.
  - `rs_data`=0x3020: fetch at 0x3020.
- Stall and reset:
  - `stall`=1 for 2 EXEC cycles: `pc`/`instr` held, `protect`=0 for 3 cycles.
  - Reset asserted mid-FETCH with ack pending: `imem_req`=0 immediately, `pc`=0x3000, the stale ack is ignored.
